// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment driver for the current/high score digits.
// Optional leading-zero blanking is enabled by defining SCORE_DISP_LZB_EN.
module score_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       show_high,
  input  logic [3:0] score1,
  input  logic [3:0] score2,
  input  logic [3:0] score3,
  input  logic [3:0] high_score1,
  input  logic [3:0] high_score2,
  input  logic [3:0] high_score3,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PDIV_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]   r_pdiv;
  logic [1:0]      r_idx;
  logic            r_first;
  logic            r_snap_high;
  logic [2:0][3:0] r_snap;
  logic [3:0]      r_an;
  logic [7:0]      r_seg;

  logic            w_tick;
  logic [2:0][3:0] w_cur;
  logic [2:0][3:0] w_high;
  logic [2:0][3:0] w_sel;
  logic            w_blank_t;
  logic            w_blank_h;
  logic            w_lit;
  logic [3:0]      w_digit;
  logic [3:0]      w_an;
  logic [7:0]      w_seg;

  assign w_tick = (r_pdiv == PDIV_MAX);
  assign w_cur  = {score3, score2, score1};
  assign w_high = {high_score3, high_score2, high_score1};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sel
      assign w_sel[gi] = show_high ? w_high[gi] : w_cur[gi];
    end
  endgenerate

`ifdef SCORE_DISP_LZB_EN
  assign w_blank_h = (r_snap[2] == 4'd0);
  assign w_blank_t = w_blank_h && (r_snap[1] == 4'd0);
`else
  assign w_blank_h = 1'b0;
  assign w_blank_t = 1'b0;
`endif

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  // Snapshot is taken at the frame boundary (or first tick) so a frame never mixes values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pdiv      <= '0;
      r_idx       <= 2'd0;
      r_first     <= 1'b1;
      r_snap_high <= 1'b0;
      r_snap      <= '0;
    end else begin
      r_pdiv <= w_tick ? '0 : r_pdiv + PW'(1);
      if (w_tick) begin
        if (r_first || r_idx == 2'd3) begin
          r_idx       <= 2'd0;
          r_first     <= 1'b0;
          r_snap_high <= show_high;
          r_snap      <= w_sel;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

  always_comb begin
    w_an    = 4'b1111;
    w_seg   = 8'hFF;
    w_lit   = 1'b0;
    w_digit = 4'd0;
    if (!r_first) begin
      case (r_idx)
        2'd0: begin
          w_lit   = 1'b1;
          w_digit = r_snap[0];
        end
        2'd1: begin
          w_lit   = !w_blank_t;
          w_digit = r_snap[1];
        end
        2'd2: begin
          w_lit   = !w_blank_h;
          w_digit = r_snap[2];
        end
        default: begin
          if (r_snap_high) begin
            w_an  = 4'b0111;
            w_seg = 8'h89;
          end
        end
      endcase
      if (w_lit) begin
        w_an  = ~(4'b0001 << r_idx);
        w_seg = f_seg(w_digit);
      end
    end
  end

  // Dark until the first snapshot has landed, then one clock behind idx.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: stimulus table, hand-written corner
// sequences and a randomized multi-frame run against a frame-level reference model.
module tb_score_display;

  localparam int RD = 4;

  logic       clk;
  logic       reset_n;
  logic       show_high;
  logic [3:0] score1, score2, score3;
  logic [3:0] high_score1, high_score2, high_score3;
  logic [3:0] an;
  logic [7:0] seg;

  int total = 0;
  int bad   = 0;

  score_display #(.REFRESH_DIV(RD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .show_high   (show_high),
    .score1      (score1),
    .score2      (score2),
    .score3      (score3),
    .high_score1 (high_score1),
    .high_score2 (high_score2),
    .high_score3 (high_score3),
    .an          (an),
    .seg         (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            sh;
    logic [3:0]      s1, s2, s3;
    logic [3:0]      h1, h2, h3;
    logic [3:0][3:0] e_an;
    logic [3:0][7:0] e_seg;
  } vec_t;

  typedef struct {
    logic       sh;
    logic [3:0] u, t, h;
  } snap_t;

  vec_t       vecs [6];
  logic [7:0] segtab [16];
  snap_t      snaps [$];

  task automatic check(input string name, input logic [3:0] ea, input logic [7:0] es);
    total++;
    if (an !== ea || seg !== es) begin
      bad++;
      $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h", name, an, seg, ea, es);
    end
  endtask

  task automatic step_check(input string name, input logic [3:0] ea, input logic [7:0] es,
                            input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check(name, ea, es);
    end
  endtask

  task automatic do_reset(input logic sh, input logic [3:0] s1, s2, s3, h1, h2, h3);
    reset_n = 1'b0;
    #1;
    check("reset dark", 4'b1111, 8'hFF);
    show_high = sh;
    score1 = s1; score2 = s2; score3 = s3;
    high_score1 = h1; high_score2 = h2; high_score3 = h3;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference: what one slot of a frame shows, given that frame's snapshot.
  task automatic model_slot(input snap_t sn, input int s, output logic [3:0] ea,
                            output logic [7:0] es);
    logic [3:0] d;
    logic       blank;
    ea = 4'b1111;
    es = 8'hFF;
    if (s == 3) begin
      if (sn.sh) begin
        ea = 4'b0111;
        es = 8'h89;
      end
    end else begin
      d = (s == 0) ? sn.u : (s == 1) ? sn.t : sn.h;
      blank = 1'b0;
`ifdef SCORE_DISP_LZB_EN
      if (s == 2 && sn.h == 0) blank = 1'b1;
      if (s == 1 && sn.h == 0 && sn.t == 0) blank = 1'b1;
`endif
      if (!blank) begin
        ea = 4'(15 - (1 << s));
        es = segtab[d];
      end
    end
  endtask

  function automatic snap_t take_snap();
    snap_t sn;
    sn.sh = show_high;
    sn.u  = show_high ? high_score1 : score1;
    sn.t  = show_high ? high_score2 : score2;
    sn.h  = show_high ? high_score3 : score3;
    return sn;
  endfunction

  initial begin
    logic [3:0] ea;
    logic [7:0] es;
    int         f, s;

    segtab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    vecs[0] = '{1'b0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {8'hFF, 8'hF9, 8'hA4, 8'hB0}};
`ifdef SCORE_DISP_LZB_EN
    vecs[1] = '{1'b1, 4'd5, 4'd5, 4'd5, 4'd9, 4'd0, 4'd0,
                {4'b0111, 4'b1111, 4'b1111, 4'b1110}, {8'h89, 8'hFF, 8'hFF, 8'h90}};
    vecs[2] = '{1'b0, 4'd1, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7,
                {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {8'hFF, 8'hFF, 8'hFF, 8'hF9}};
    vecs[5] = '{1'b0, 4'd0, 4'd4, 4'd0, 4'd1, 4'd1, 4'd1,
                {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {8'hFF, 8'hFF, 8'h99, 8'hC0}};
`else
    vecs[1] = '{1'b1, 4'd5, 4'd5, 4'd5, 4'd9, 4'd0, 4'd0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'h89, 8'hC0, 8'hC0, 8'h90}};
    vecs[2] = '{1'b0, 4'd1, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {8'hFF, 8'hC0, 8'hC0, 8'hF9}};
    vecs[5] = '{1'b0, 4'd0, 4'd4, 4'd0, 4'd1, 4'd1, 4'd1,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {8'hFF, 8'hC0, 8'h99, 8'hC0}};
`endif
    vecs[3] = '{1'b0, 4'd5, 4'd0, 4'hA, 4'd2, 4'd2, 4'd2,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {8'hFF, 8'hBF, 8'hC0, 8'h92}};
    vecs[4] = '{1'b1, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd6,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'h89, 8'h82, 8'h80, 8'hF8}};

    reset_n = 1'b1;
    show_high = 1'b0;
    score1 = '0; score2 = '0; score3 = '0;
    high_score1 = '0; high_score2 = '0; high_score3 = '0;
    #2;

    // Table: one full frame after reset, every cycle compared.
    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].sh, vecs[v].s1, vecs[v].s2, vecs[v].s3,
               vecs[v].h1, vecs[v].h2, vecs[v].h3);
      step_check($sformatf("vec%0d pre-tick", v), 4'b1111, 8'hFF, RD);
      for (int k = 0; k < 4; k++)
        step_check($sformatf("vec%0d slot%0d", v, k), vecs[v].e_an[k], vecs[v].e_seg[k], RD);
      step_check($sformatf("vec%0d frame1 slot0", v), vecs[v].e_an[0], vecs[v].e_seg[0], 1);
      $display("vec %0d: sh=%0d score=%0d%0d%0d high=%0d%0d%0d checked", v, vecs[v].sh,
               vecs[v].s3, vecs[v].s2, vecs[v].s1, vecs[v].h3, vecs[v].h2, vecs[v].h1);
    end

    // Snapshot integrity: units changes 3->4 while tens slot is being shown.
    do_reset(1'b0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0);
    step_check("snap pre", 4'b1111, 8'hFF, RD);
    step_check("snap u old", 4'b1110, 8'hB0, RD);
    step_check("snap t", 4'b1101, 8'hA4, 1);
    score1 = 4'd4;
    step_check("snap t", 4'b1101, 8'hA4, RD - 1);
    step_check("snap h", 4'b1011, 8'hF9, RD);
    step_check("snap dark", 4'b1111, 8'hFF, RD);
    step_check("snap u new", 4'b1110, 8'h99, RD);
    $display("seq snapshot: units update deferred to next frame checked");

    // Async reset mid-slot: outputs go dark with no clock edge.
    do_reset(1'b0, 4'd8, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0);
    step_check("async pre", 4'b1111, 8'hFF, RD);
    step_check("async lit", 4'b1110, 8'h80, 2);
    reset_n = 1'b0;
    #1;
    check("async dark", 4'b1111, 8'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    step_check("async restart pre", 4'b1111, 8'hFF, RD);
    step_check("async restart u", 4'b1110, 8'h80, 1);
    $display("seq async reset: dark immediately, restart checked");

    // Randomized multi-frame run with inputs changing at arbitrary cycles.
    do_reset(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom), 4'($urandom));
    snaps.delete();
    for (int e = 1; e <= 16 * RD + 4 * RD + 1; e++) begin
      @(posedge clk);
      if (e >= RD && (e - RD) % (4 * RD) == 0) snaps.push_back(take_snap());
      #1;
      if (e <= RD) begin
        ea = 4'b1111;
        es = 8'hFF;
      end else begin
        f = (e - RD - 1) / (4 * RD);
        s = ((e - RD - 1) % (4 * RD)) / RD;
        model_slot(snaps[f], s, ea, es);
      end
      check($sformatf("rand edge%0d", e), ea, es);
      if ((e - RD - 1) % (4 * RD) == 0 && e > RD)
        $display("rand frame %0d: sh=%0d digits=%0d/%0d/%0d", f, snaps[f].sh,
                 snaps[f].h, snaps[f].t, snaps[f].u);
      if ($urandom_range(0, 3) == 0) begin
        show_high   = 1'($urandom);
        score1      = 4'($urandom);
        score2      = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom);
        score3      = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom);
        high_score1 = 4'($urandom);
        high_score2 = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom);
        high_score3 = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Four-digit multiplexed seven-segment driver for the score digits. It is the reader side of the score counter's BCD outputs: it takes the three current-score digits and the three high-score digits and time-multiplexes them onto a common-anode display. A frame-boundary snapshot ensures one displayed frame never mixes two score values. It sits between the score counter and the board's anode and segment pins.

## Interface
- REFRESH_DIV, default 50000: clocks per digit slot. Must be ≥ 2. 100 MHz gives a 2 kHz slot rate and a 500 Hz frame rate.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- show_high  in  1  1 = display the high score, 0 = display the current score
- score1, score2, score3  in  4 each  current score BCD digits: units, tens, hundreds
- high_score1, high_score2, high_score3  in  4 each  high-score BCD digits: units, tens, hundreds
- an  out  4  digit enables, active low; an[0] is the rightmost digit
- seg  out  8  segments, active low; seg[6:0] = g..a, seg[7] = dp (always 1)

## Operation
- **Prescaler**
  - pdiv counts 0 to REFRESH_DIV-1 and wraps.
  - Internal strobe tick = (pdiv == REFRESH_DIV-1).
- **Slot index**
  - idx is 2 bits and advances 0→1→2→3→0 on each tick.
- **Snapshot**
  - Taken on every tick where idx == 3, or on the first tick after reset. The next idx is 0.
  - Captured: show_high, plus three digits selected by show_high (current-score or high-score set).
  - Inputs are ignored between snapshots. A mid-frame change of show_high or of the digits appears on the next frame only.
- **Slot content** (a function of the registered idx and the snapshot):
  - idx 0: units digit on an[0]
  - idx 1: tens digit on an[1]
  - idx 2: hundreds digit on an[2]
  - idx 3: 'H' on an[3] if the snapshot show_high is 1; otherwise an = 4'b1111 and seg = 8'hFF (slot dark).
- **Segment codes** (seg, hex, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - H=89, blank=FF
  - Any BCD value 10–15 displays a dash, BF. This covers the hundreds digit when the score is ≥ 1000.
- **Anodes**
  - Exactly one an bit is low when a digit is lit.
  - All an bits are high for a dark slot or a blanked slot; seg = FF in both cases.

## Timing
- **Reset** (reset_n low, asynchronous): pdiv=0, idx=0, snapshot cleared, an=4'b1111, seg=8'hFF, first-tick flag set.
- **Pipeline**
  - tick is high in cycle T.
  - idx and the snapshot update at the rising edge ending cycle T.
  - an and seg are registered and update on the following edge.
  - Latency is therefore 1 clock from the idx update to the pins.
- **After reset release**
  - The first tick edge is the REFRESH_DIV-th rising edge.
  - The first lit digit (units) appears one edge later.
  - Outputs stay dark until then.
- **Slot and frame length**: each slot lasts exactly REFRESH_DIV clocks; a frame lasts 4·REFRESH_DIV clocks.
- **Reset mid-frame**: outputs go dark immediately (asynchronous). The sequence restarts as after power-up.
- **show_high and digit inputs**: sampled only on the snapshot edge; no synchronizer is required beyond clk.

## Configuration
- **SCORE_DISP_LZB_EN defined**: leading-zero blanking, evaluated on the snapshot.
  - The hundreds slot is blanked when hundreds == 0.
  - The tens slot is blanked when hundreds == 0 and tens == 0.
  - The units digit is always lit.
  - A blanked slot drives an=4'b1111 and seg=FF.
- **SCORE_DISP_LZB_EN undefined**: all three digit slots are always lit, and zeros display as C0.

## Test plan
Benches run with REFRESH_DIV=4.
- **Reset**: hold reset_n low, then release → an=1111 and seg=FF until 1 edge after the 4th rising edge; then an=1110, seg=F9 for score1=1.
- **Current score**: show_high=0, score = 3/2/1 (units/tens/hundreds) → an/seg sequence per frame is 1110/B0, 1101/A4, 1011/F9, 1111/FF, each lasting 4 clocks.
- **High score**: show_high=1, high score = 9/0/0 with SCORE_DISP_LZB_EN defined → 1110/90, 1111/FF, 1111/FF, 0111/89. With the macro undefined, slots 1 and 2 show 1101/C0 and 1011/C0.
- **Snapshot integrity**: change score1 from 3 to 4 while idx=1 → the rest of the frame is unchanged; the units slot shows 99 only in the next frame.
- **Invalid BCD and async reset**: score3=4'hA → hundreds slot 1011/BF. Pull reset_n low mid-slot → an=1111 and seg=FF within the same cycle, with no clock edge needed.
